// File: rtl/simu_rec_seq.sv
// AXI4-Lite register sequencer: writes SEED+i to NUM_REGS consecutive slave registers,
// reads them back, and reports read-back mismatches, error responses and handshake timeouts.
module simu_rec_seq #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter int                            NUM_REGS           = 4,
    parameter logic [31:0]                   SEED               = 32'h0000_0001,
    parameter int                            TIMEOUT_CYC        = 1024
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [7:0]                    err_cnt,
    output logic                          timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [2:0]                    o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int              AW       = C_M_AXI_ADDR_WIDTH;
    localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TLAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      LAST_IDX = 4'(NUM_REGS - 1);

    state_t        r_state, w_next;
    logic [3:0]    r_idx, w_idx_next;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_err_cnt;
    logic          r_timeout, r_pass, r_awvalid, r_wvalid;
    logic [AW-1:0] r_awaddr, r_araddr, w_addr_next;
    logic [31:0]   r_wdata;
    logic          w_err_inc, w_tmo, w_tlast, w_aw_ok, w_w_ok, w_pass_now;

    // Handshake rule: a transfer happens on a rising edge where VALID and READY are both
    // high; VALID is held until then and only timeout or reset may withdraw it early.
    assign w_tlast     = (r_tcnt == TLAST);
    assign w_aw_ok     = !r_awvalid || M_AXI_AWREADY;
    assign w_w_ok      = !r_wvalid || M_AXI_WREADY;
    assign w_pass_now  = (r_err_cnt == 8'd0) && !r_timeout;
    assign w_addr_next = C_BASE_ADDR + AW'({w_idx_next, 2'b00});

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_err_inc  = 1'b0;
        w_tmo      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next     = S_WR_REQ;
                    w_idx_next = 4'd0;
                end
            end
            S_WR_REQ: begin
                if (w_aw_ok && w_w_ok) begin
                    w_next = S_WR_RESP;
                end else if (w_tlast) begin
                    w_next = S_DONE;
                    w_tmo  = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    w_err_inc = (M_AXI_BRESP != 2'b00);
                    if (r_idx == LAST_IDX) begin
                        w_next     = S_RD_REQ;
                        w_idx_next = 4'd0;
                    end else begin
                        w_next     = S_WR_REQ;
                        w_idx_next = r_idx + 4'd1;
                    end
                end else if (w_tlast) begin
                    w_next = S_DONE;
                    w_tmo  = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    w_next = S_RD_RESP;
                end else if (w_tlast) begin
                    w_next = S_DONE;
                    w_tmo  = 1'b1;
                end
            end
            S_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    // A wrong value with an error response still counts as one fault.
                    w_err_inc = (M_AXI_RDATA != SEED + 32'(r_idx)) || (M_AXI_RRESP != 2'b00);
                    if (r_idx == LAST_IDX) begin
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_RD_REQ;
                        w_idx_next = r_idx + 4'd1;
                    end
                end else if (w_tlast) begin
                    w_next = S_DONE;
                    w_tmo  = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_idx     <= '0;
            r_tcnt    <= '0;
            r_err_cnt <= '0;
            r_timeout <= 1'b0;
            r_pass    <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
        end else begin
            r_idx  <= w_idx_next;
            r_tcnt <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_tcnt + TW'(1);
            if (r_state == S_IDLE && start) begin
                r_err_cnt <= '0;
                r_timeout <= 1'b0;
                r_pass    <= 1'b0;
            end else begin
                if (w_err_inc && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                if (w_tmo) r_timeout <= 1'b1;
                if (r_state == S_DONE) r_pass <= w_pass_now;
            end
            // AW and W retire independently; each VALID falls the cycle after its own transfer.
            if (w_next == S_WR_REQ && r_state != S_WR_REQ) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= w_addr_next;
                r_wdata   <= SEED + 32'(w_idx_next);
            end else if (r_state == S_WR_REQ && w_next == S_WR_REQ) begin
                r_awvalid <= r_awvalid & ~M_AXI_AWREADY;
                r_wvalid  <= r_wvalid & ~M_AXI_WREADY;
            end else begin
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
            end
            if (w_next == S_RD_REQ && r_state != S_RD_REQ) r_araddr <= w_addr_next;
        end
    end

    assign busy          = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                           (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
    assign done          = (r_state == S_DONE);
    assign pass          = done ? w_pass_now : r_pass;
    assign err_cnt       = r_err_cnt;
    assign timeout       = r_timeout;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = (r_state == S_WR_RESP);
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (r_state == S_RD_REQ);
    assign M_AXI_RREADY  = (r_state == S_RD_RESP);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_simu_rec_seq.sv
// Bench for simu_rec_seq: a behavioural AXI4-Lite slave with random stalls and injectable
// faults, plus a reference model of the expected write/read traffic and final result.
module tb_simu_rec_seq;
  localparam int          AW   = 32;
  localparam int          NR   = 4;
  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          TMO  = 16;

  logic ACLK = 1'b0;
  logic ARESETN, start;
  logic busy, done, pass, timeout;
  logic [7:0] err_cnt;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot, dbg_state;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;

  simu_rec_seq #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_BASE_ADDR(BASE), .NUM_REGS(NR), .SEED(SEED), .TIMEOUT_CYC(TMO)
  ) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .timeout(timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: expected {addr,data} per write and expected address per read
  logic [63:0] exp_q[$];
  logic [31:0] exp_rd_q[$];

  // slave state and fault configuration
  logic [31:0] mem[16];
  logic [15:0] b_bad, r_bad, r_cor;
  bit   force_aw3, ar_stuck, start_noise;
  int   dmax, b_hold;
  int   cyc, aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int   aw_dly, w_dly, b_dly, ar_dly, r_dly;
  bit   aw_got, w_got, wr_logged, b_hs, ar_got, r_hs;
  int   wr_log_cyc, ar_cyc, wr_idx, rd_idx;
  int   aw_hi, w_hi, ar_hi, aw_hi_first, w_hi_first, proto_err;
  logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
  logic [3:0]  wr_reg, rd_reg;

  task automatic new_wr_dly();
    aw_dly = force_aw3 ? 3 : int'($urandom_range(0, dmax));
    w_dly  = force_aw3 ? 0 : int'($urandom_range(0, dmax));
    b_dly  = (b_hold >= 0) ? b_hold : int'($urandom_range(0, dmax));
  endtask

  task automatic new_rd_dly();
    ar_dly = int'($urandom_range(0, dmax));
    r_dly  = int'($urandom_range(0, dmax));
  endtask

  task automatic slave_clear();
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    arready = 0; rvalid = 0; rresp = 2'b00; rdata = '0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; wr_logged = 0; b_hs = 0; ar_got = 0; r_hs = 0;
    wr_idx = 0; rd_idx = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
    aw_hi_first = -1; w_hi_first = -1; proto_err = 0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    new_wr_dly();
    new_rd_dly();
  endtask

  // one slave step per falling edge; transfers complete on the following rising edge
  task automatic slave_step();
    logic [31:0] off;
    cyc++;
    if (b_hs) begin
      if (wr_idx == 0) begin aw_hi_first = aw_hi; w_hi_first = w_hi; end
      bvalid = 0; b_hs = 0; aw_got = 0; w_got = 0; wr_logged = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; aw_hi = 0; w_hi = 0;
      wr_idx++;
      new_wr_dly();
    end
    if (r_hs) begin
      rvalid = 0; r_hs = 0; ar_got = 0; ar_wait = 0; r_wait = 0;
      rd_idx++;
      new_rd_dly();
    end
    awready = 0; wready = 0; arready = 0;
    if (bready && !(wr_logged && cyc > wr_log_cyc)) proto_err++;
    if (rready && !(ar_got && cyc > ar_cyc)) proto_err++;
    if (awvalid) begin
      aw_hi++;
      if (aw_got) proto_err++;
      else if (aw_wait >= aw_dly) begin awready = 1; aw_got = 1; aw_addr_s = awaddr; end
      else aw_wait++;
    end
    if (wvalid) begin
      w_hi++;
      if (wstrb != 4'hF) proto_err++;
      if (w_got) proto_err++;
      else if (w_wait >= w_dly) begin wready = 1; w_got = 1; w_data_s = wdata; end
      else w_wait++;
    end
    if (aw_got && w_got && !wr_logged) begin
      wr_logged = 1; wr_log_cyc = cyc;
      if (exp_q.size() == 0) check_eq("wr_unexpected", {aw_addr_s, w_data_s}, 64'h0);
      else check_eq("wr_addr_data", {aw_addr_s, w_data_s}, exp_q.pop_front());
      off = (aw_addr_s - BASE) >> 2;
      wr_reg = off[3:0];
      mem[wr_reg] = w_data_s;
    end
    if (wr_logged && cyc > wr_log_cyc && !b_hs) begin
      if (!bvalid) begin
        if (b_wait >= b_dly) begin bvalid = 1; bresp = b_bad[wr_reg] ? 2'b10 : 2'b00; end
        else b_wait++;
      end
      if (bvalid && bready) b_hs = 1;
    end
    if (arvalid) begin
      ar_hi++;
      if (ar_got) proto_err++;
      else if (!ar_stuck && ar_wait >= ar_dly) begin
        arready = 1; ar_got = 1; ar_cyc = cyc; ar_addr_s = araddr;
        if (exp_rd_q.size() == 0) check_eq("rd_unexpected", araddr, 32'hFFFF_FFFF);
        else check_eq("rd_addr", araddr, exp_rd_q.pop_front());
        off = (araddr - BASE) >> 2;
        rd_reg = off[3:0];
      end else ar_wait++;
    end
    if (ar_got && cyc > ar_cyc && !r_hs) begin
      if (!rvalid) begin
        if (r_wait >= r_dly) begin
          rvalid = 1;
          rdata  = r_cor[rd_reg] ? 32'h0000_DEAD : mem[rd_reg];
          rresp  = r_bad[rd_reg] ? 2'b10 : 2'b00;
        end else r_wait++;
      end
      if (rvalid && rready) r_hs = 1;
    end
  endtask

  // reference model: the traffic and result the sequence must produce
  task automatic build_model(input bit exp_tmo, output int exp_err);
    exp_q.delete();
    exp_rd_q.delete();
    exp_err = 0;
    for (int k = 0; k < NR; k++) begin
      exp_q.push_back({BASE + 32'(4 * k), SEED + 32'(k)});
      exp_err += int'(b_bad[k]);
      if (!exp_tmo) begin
        exp_rd_q.push_back(BASE + 32'(4 * k));
        exp_err += int'(r_bad[k] | r_cor[k]);
      end
    end
  endtask

  task automatic run_seq(input string tag, input bit exp_tmo);
    int  exp_err;
    bit  exp_pass, got_done;
    build_model(exp_tmo, exp_err);
    exp_pass = (exp_err == 0) && !exp_tmo;
    slave_clear();
    start = 1;
    @(negedge ACLK); slave_step();
    start = 0;
    check_eq({tag, "_busy_after_start"}, busy, 1);
    got_done = 0;
    for (int g = 0; g < 1000 && !got_done; g++) begin
      if (start_noise) start = ($urandom_range(0, 3) == 0);
      @(negedge ACLK); slave_step();
      if (done) got_done = 1;
    end
    start = 0;
    check_eq({tag, "_done_seen"}, got_done, 1);
    if (!got_done) return;
    check_eq({tag, "_busy_at_done"}, busy, 0);
    check_eq({tag, "_pass"}, pass, exp_pass);
    check_eq({tag, "_err_cnt"}, err_cnt, 8'(exp_err));
    check_eq({tag, "_timeout"}, timeout, exp_tmo);
    check_eq({tag, "_writes"}, wr_idx, NR);
    check_eq({tag, "_reads"}, rd_idx, exp_tmo ? 0 : NR);
    check_eq({tag, "_wr_left"}, exp_q.size(), 0);
    check_eq({tag, "_rd_left"}, exp_rd_q.size(), 0);
    check_eq({tag, "_protocol"}, proto_err, 0);
    check_eq({tag, "_valids_at_done"}, {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    @(negedge ACLK); slave_step();
    check_eq({tag, "_done_one_cycle"}, done, 0);
    check_eq({tag, "_pass_hold"}, pass, exp_pass);
    check_eq({tag, "_err_hold"}, err_cnt, 8'(exp_err));
    check_eq({tag, "_tmo_hold"}, timeout, exp_tmo);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_status"}, {busy, done, pass, timeout, err_cnt}, 12'h0);
    check_eq({tag, "_vr"}, {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check_eq({tag, "_awaddr"}, awaddr, 32'h0);
    check_eq({tag, "_wdata"}, wdata, 32'h0);
    check_eq({tag, "_araddr"}, araddr, 32'h0);
    check_eq({tag, "_const"}, {awprot, arprot, wstrb}, {6'b0, 4'hF});
  endtask

  task automatic clear_cfg();
    b_bad = '0; r_bad = '0; r_cor = '0;
    force_aw3 = 0; ar_stuck = 0; start_noise = 0; dmax = 0; b_hold = -1;
  endtask

  initial begin
    bit seen;
    cyc = 0;
    clear_cfg();
    start = 0;
    ARESETN = 0;
    slave_clear();
    repeat (3) @(negedge ACLK);
    check_cleared("reset");
    ARESETN = 1;
    @(negedge ACLK);

    // zero-wait slave, clean run
    run_seq("basic", 0);

    // AWREADY after 3 cycles, WREADY immediately
    clear_cfg(); force_aw3 = 1;
    run_seq("aw_delay", 0);
    check_eq("aw_valid_cycles", aw_hi_first, 4);
    check_eq("w_valid_cycles", w_hi_first, 1);

    // SLVERR on write 1, 0xDEAD read from register 2
    clear_cfg(); b_bad = 16'h0002; r_cor = 16'h0004;
    run_seq("faults", 0);

    // ARREADY never rises
    clear_cfg(); ar_stuck = 1;
    run_seq("ar_timeout", 1);
    check_eq("ar_valid_cycles", ar_hi, TMO);

    // reset while waiting for the third write response
    clear_cfg(); b_bad = 16'h0001; b_hold = 12;
    begin
      int dummy;
      build_model(0, dummy);
    end
    slave_clear();
    start = 1;
    @(negedge ACLK); slave_step();
    start = 0;
    seen = 0;
    for (int g = 0; g < 200 && !seen; g++) begin
      @(negedge ACLK); slave_step();
      if (bready && wr_idx == 2) seen = 1;
    end
    check_eq("rst_mid_reached", seen, 1);
    check_eq("rst_mid_err_before", err_cnt, 8'd1);
    #2 ARESETN = 0;
    #1 check_cleared("rst_mid");
    @(negedge ACLK);
    slave_clear();
    @(negedge ACLK);
    ARESETN = 1;
    @(negedge ACLK);
    clear_cfg();
    run_seq("rst_rerun", 0);

    // random stalls and faults, with start pulses while busy
    for (int r = 0; r < 10; r++) begin
      clear_cfg();
      dmax = int'($urandom_range(0, 4));
      start_noise = 1;
      if ($urandom_range(0, 1) == 1) b_bad = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) r_bad = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) r_cor = 16'($urandom_range(0, 15));
      run_seq("rand", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
